// File: rtl/demux1to2_4w_buf_if.sv
// Bus bundle for the buffered 1-to-2 demux.
//   slave  : demux side. Takes i/s/i_valid and y*_ready; drives i_ready, y*, y*_valid and cnt*.
//   master : producer/consumer side, the mirror image of slave.
interface demux1to2_4w_buf_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
);
    logic [W-1:0]  i;
    logic          s;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  y0;
    logic          y0_valid;
    logic          y0_ready;
    logic [W-1:0]  y1;
    logic          y1_valid;
    logic          y1_ready;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    modport slave (
        input  i, s, i_valid, y0_ready, y1_ready,
        output i_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
    );

    modport master (
        output i, s, i_valid, y0_ready, y1_ready,
        input  i_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux1to2_4w_buf.sv
// Buffered 1-to-2 demultiplexer for W-bit words.
// A single valid/ready input stream carries a select bit s. Each accepted word
// goes into the FIFO of channel s. Each FIFO drives its own valid/ready output.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave view of demux1to2_4w_buf_if. It carries:
//                - the input stream: i, s, i_valid, i_ready
//                - per-channel outputs: yk, yk_valid, yk_ready
//                - per-channel accepted-word counters: cnt0, cnt1
module demux1to2_4w_buf #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1to2_4w_buf_if.slave bus
);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW  = $clog2(DEPTH + 1);
    localparam int unsigned NCH = 2;

    logic [W-1:0]   mem    [NCH][DEPTH];
    logic [PW-1:0]  wr_ptr [NCH];
    logic [PW-1:0]  rd_ptr [NCH];
    logic [OW-1:0]  occ    [NCH];
    logic [CW-1:0]  cnt    [NCH];
    logic [W-1:0]   head   [NCH];
    logic [NCH-1:0] full;
    logic [NCH-1:0] valid;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           accept;

    assign ready = {bus.y1_ready, bus.y0_ready};

    // Occupancy flags and per-channel push/pop strobes.
    // A full channel refuses a push even when it pops in the same cycle,
    // so the path from y*_ready to i_ready stays cut.
    always_comb begin
        full = '0;
        valid = '0;
        push = '0;
        pop = '0;
        for (int k = 0; k < NCH; k++) begin
            full[k]  = (occ[k] == OW'(DEPTH));
            valid[k] = (occ[k] != '0);
            pop[k]   = valid[k] & ready[k];
        end
        accept = bus.i_valid & ~full[bus.s];
        for (int k = 0; k < NCH; k++) begin
            push[k] = accept & (bus.s == 1'(k));
        end
    end

    // FIFO storage, pointers, occupancy and counters for both channels.
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                occ[k]    <= '0;
                cnt[k]    <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= bus.i;
                    wr_ptr[k]         <= wr_ptr[k] + PW'(1);
                    cnt[k]            <= cnt[k] + CW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PW'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   occ[k] <= occ[k] + OW'(1);
                    2'b01:   occ[k] <= occ[k] - OW'(1);
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

    // The head word is AND-gated with valid, so an empty channel shows zero.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            head[k] = mem[k][rd_ptr[k]] & {W{valid[k]}};
        end
    end

    assign bus.i_ready  = ~full[bus.s];
    assign bus.y0       = head[0];
    assign bus.y0_valid = valid[0];
    assign bus.y1       = head[1];
    assign bus.y1_valid = valid[1];
    assign bus.cnt0     = cnt[0];
    assign bus.cnt1     = cnt[1];
endmodule
